// File: rtl/implication_arbiter_if.sv
// Lane request/ack and implication-drain signals bundled for implication_arbiter.
// slave = arbiter side, master = evaluator lanes plus downstream consumer.
interface implication_arbiter_if #(
    parameter int NUM_LANES  = 4,
    parameter int VAR_W      = 9,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                       flush;
    logic [NUM_LANES-1:0]       lane_req;
    logic [NUM_LANES*VAR_W-1:0] lane_var;
    logic [NUM_LANES-1:0]       lane_val;
    logic [NUM_LANES-1:0]       lane_ack;
    logic                       imp_valid;
    logic [VAR_W-1:0]           imp_var;
    logic                       imp_val;
    logic                       imp_ready;
    logic [CNT_W-1:0]           fifo_count;
    logic                       fifo_full;
    logic                       conflict;

    modport slave (
        input  flush, lane_req, lane_var, lane_val, imp_ready,
        output lane_ack, imp_valid, imp_var, imp_val, fifo_count, fifo_full, conflict
    );

    modport master (
        output flush, lane_req, lane_var, lane_val, imp_ready,
        input  lane_ack, imp_valid, imp_var, imp_val, fifo_count, fifo_full, conflict
    );
endinterface

// File: rtl/implication_arbiter.sv
// Round-robin merge of lane implications into a FIFO; ack is combinational, head valid 1 cycle after push,
// lanes stall (no ack) while the FIFO is full without a pop. IMPLICATION_CONFLICT_EN enables the sticky conflict flag.
module implication_arbiter #(
    parameter int NUM_LANES  = 4,
    parameter int VAR_W      = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    implication_arbiter_if.slave  bus
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [VAR_W-1:0] vidx;
        logic             val;
    } imp_t;

    logic [LANE_W-1:0] rr_ptr;
    logic [LANE_W-1:0] rr_next;
    logic [LANE_W-1:0] winner;
    logic              found;
    int                idx;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    imp_t              mem [FIFO_DEPTH];
    imp_t              win_dat;
    imp_t              head;
    logic              valid;
    logic              full;
    logic              pop;
    logic              space;
    logic              push;

    assign valid = (count != '0);
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop   = valid & bus.imp_ready & ~bus.flush;
    assign space = ~full | (valid & bus.imp_ready);

    // First requester at or after rr_ptr, wrapping modulo NUM_LANES.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_LANES;
            if (!found && bus.lane_req[idx]) begin
                found  = 1'b1;
                winner = LANE_W'(idx);
            end
        end
    end

    assign push    = found & space & ~bus.flush & rst_n;
    assign rr_next = (winner == LANE_W'(NUM_LANES - 1)) ? '0 : winner + LANE_W'(1);
    assign win_dat = '{vidx: bus.lane_var[int'(winner)*VAR_W +: VAR_W], val: bus.lane_val[winner]};

    always_comb begin
        bus.lane_ack = '0;
        if (push) bus.lane_ack[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= rr_next;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= win_dat;
    end

    assign head           = mem[rd_ptr];
    assign bus.imp_valid  = valid;
    assign bus.imp_var    = valid ? head.vidx : '0;
    assign bus.imp_val    = valid ? head.val  : 1'b0;
    assign bus.fifo_count = count;
    assign bus.fifo_full  = full;

`ifdef IMPLICATION_CONFLICT_EN
    logic clash;
    logic conflict_q;

    // Same variable implied with both polarities by two live requests.
    always_comb begin
        clash = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (bus.lane_req[i] && bus.lane_req[j] &&
                    (bus.lane_var[i*VAR_W +: VAR_W] == bus.lane_var[j*VAR_W +: VAR_W]) &&
                    (bus.lane_val[i] != bus.lane_val[j]))
                    clash = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         conflict_q <= 1'b0;
        else if (bus.flush) conflict_q <= 1'b0;
        else if (clash)     conflict_q <= 1'b1;
    end

    assign bus.conflict = conflict_q;
`else
    assign bus.conflict = 1'b0;
`endif
endmodule

// File: tb/tb_implication_arbiter.sv
// Directed bench for implication_arbiter: expected drain entries go into a queue, a monitor pops and compares on each handshake.
module tb_implication_arbiter;
    localparam int NL = 4;
    localparam int VW = 9;
    localparam int FD = 8;
`ifdef IMPLICATION_CONFLICT_EN
    localparam logic CEN = 1'b1;
`else
    localparam logic CEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [VW:0]   exp_q[$];
    logic [NL-1:0] last_ack;

    implication_arbiter_if #(.NUM_LANES(NL), .VAR_W(VW), .FIFO_DEPTH(FD)) bus ();

    implication_arbiter #(.NUM_LANES(NL), .VAR_W(VW), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.imp_valid && bus.imp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected: got var=0x%0h val=%0b with nothing expected", bus.imp_var, bus.imp_val);
            end else begin
                logic [VW:0] e;
                e = exp_q.pop_front();
                if ({bus.imp_var, bus.imp_val} !== e) begin
                    errors++;
                    $display("FAIL drain_entry: got var=0x%0h val=%0b expected var=0x%0h val=%0b",
                             bus.imp_var, bus.imp_val, e[VW:1], e[0]);
                end
            end
        end
    end

    task automatic step_neg();
        @(negedge clk);
        last_ack = bus.lane_ack;
    endtask

    // Advance past the edge; acked lanes drop their request as the lane contract requires.
    task automatic step_pos();
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) if (last_ack[i]) bus.lane_req[i] = 1'b0;
        last_ack = '0;
    endtask

    task automatic set_lane(input int l, input logic [VW-1:0] v, input logic b, input logic expect_accept);
        bus.lane_var[l*VW +: VW] = v;
        bus.lane_val[l]          = b;
        bus.lane_req[l]          = 1'b1;
        if (expect_accept) exp_q.push_back({v, b});
    endtask

    task automatic drain(input string name);
        bus.imp_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            step_neg();
            step_pos();
        end
        chk({name, "_left"}, exp_q.size(), 0);
        step_neg();
        chk({name, "_count"}, bus.fifo_count, 0);
        step_pos();
    endtask

    task automatic push_single(input string name, input int l, input logic [VW-1:0] v, input logic b);
        set_lane(l, v, b, 1'b1);
        step_neg();
        chk(name, bus.lane_ack, 1 << l);
        step_pos();
    endtask

    initial begin
        rst_n         = 1'b0;
        last_ack      = '0;
        bus.flush     = 1'b0;
        bus.lane_req  = '0;
        bus.lane_var  = '0;
        bus.lane_val  = '0;
        bus.imp_ready = 1'b0;
        #1;
        chk("rst_valid", bus.imp_valid, 0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_full",  bus.fifo_full, 0);
        chk("rst_var",   {bus.imp_var, bus.imp_val}, 0);
        chk("rst_ack",   bus.lane_ack, 0);
        chk("rst_conflict", bus.conflict, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin from reset: all lanes request, acks and drain in lane order.
        for (int i = 0; i < NL; i++) set_lane(i, VW'(9'h010 + i), 1'(i & 1), 1'b1);
        bus.imp_ready = 1'b1;
        for (int k = 0; k < NL; k++) begin
            step_neg();
            chk("rr_ack", bus.lane_ack, 1 << k);
            if (k == 0) chk("rr_first_latency", bus.imp_valid, 0);
            step_pos();
        end
        drain("rr_drain");

        // Single push into empty FIFO: visible one cycle after the ack.
        set_lane(2, 9'h1A5, 1'b1, 1'b1);
        step_neg();
        chk("lat_ack", bus.lane_ack, 4'b0100);
        chk("lat_valid_n", bus.imp_valid, 0);
        step_pos();
        step_neg();
        chk("lat_valid_n1", bus.imp_valid, 1);
        chk("lat_var", bus.imp_var, 9'h1A5);
        chk("lat_val", bus.imp_val, 1);
        step_pos();
        chk("lat_count", bus.fifo_count, 0);

        // Fill to full under backpressure, then simultaneous pop and push at full.
        bus.imp_ready = 1'b0;
        for (int n = 0; n < FD; n++) push_single("full_ack", n % NL, VW'(9'h100 + n), 1'(n & 1));
        set_lane(0, 9'h108, 1'b0, 1'b1);
        step_neg();
        chk("full_ninth_held", bus.lane_ack, 0);
        chk("full_flag", bus.fifo_full, 1);
        chk("full_count", bus.fifo_count, FD);
        step_pos();
        bus.imp_ready = 1'b1;
        step_neg();
        chk("full_popush_ack", bus.lane_ack, 4'b0001);
        step_pos();
        bus.imp_ready = 1'b0;
        chk("full_popush_count", bus.fifo_count, FD);
        chk("full_popush_flag", bus.fifo_full, 1);
        drain("full_drain");

        // Flush with 5 entries and a pending request; rr_ptr must return to 0.
        bus.imp_ready = 1'b0;
        push_single("fl_ack", 0, 9'h0A0, 1'b0);
        push_single("fl_ack", 1, 9'h0A1, 1'b1);
        push_single("fl_ack", 2, 9'h0A2, 1'b0);
        push_single("fl_ack", 3, 9'h0A3, 1'b1);
        push_single("fl_ack", 1, 9'h0A4, 1'b0);
        chk("fl_count_pre", bus.fifo_count, 5);
        set_lane(1, 9'h155, 1'b0, 1'b0);
        bus.flush = 1'b1;
        step_neg();
        chk("fl_no_ack", bus.lane_ack, 0);
        step_pos();
        bus.flush = 1'b0;
        exp_q.delete();
        chk("fl_count", bus.fifo_count, 0);
        chk("fl_valid", bus.imp_valid, 0);
        exp_q.push_back({9'h155, 1'b0});
        set_lane(3, 9'h133, 1'b1, 1'b1);
        step_neg();
        chk("fl_rr_reset", bus.lane_ack, 4'b0010);
        step_pos();
        step_neg();
        chk("fl_rr_next", bus.lane_ack, 4'b1000);
        step_pos();
        drain("fl_drain");

        // Conflicting polarity for the same variable on lanes 0 and 3.
        set_lane(0, 9'h042, 1'b0, 1'b1);
        set_lane(3, 9'h042, 1'b1, 1'b1);
        bus.imp_ready = 1'b1;
        step_neg();
        chk("cf_before", bus.conflict, 0);
        chk("cf_ack0", bus.lane_ack, 4'b0001);
        step_pos();
        step_neg();
        chk("cf_set", bus.conflict, CEN);
        chk("cf_ack3", bus.lane_ack, 4'b1000);
        step_pos();
        drain("cf_drain");
        chk("cf_sticky", bus.conflict, CEN);
        bus.flush = 1'b1;
        step_neg();
        step_pos();
        bus.flush = 1'b0;
        chk("cf_flush", bus.conflict, 0);

        // Asynchronous reset with 3 entries held and a lane requesting.
        bus.imp_ready = 1'b0;
        push_single("mr_ack", 0, 9'h0E0, 1'b1);
        push_single("mr_ack", 1, 9'h0E1, 1'b0);
        push_single("mr_ack", 2, 9'h0E2, 1'b1);
        chk("mr_count_pre", bus.fifo_count, 3);
        set_lane(3, 9'h0E3, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", bus.imp_valid, 0);
        chk("mr_count", bus.fifo_count, 0);
        chk("mr_var", {bus.imp_var, bus.imp_val}, 0);
        chk("mr_ack", bus.lane_ack, 0);
        chk("mr_full", bus.fifo_full, 0);
        exp_q.delete();
        bus.lane_req = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_ack = '0;
        step_neg();
        chk("mr_after_count", bus.fifo_count, 0);
        chk("mr_after_valid", bus.imp_valid, 0);
        step_pos();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
